imm_arbiter: RTL and testbench
==============================

# imm_arbiter

Shares a single sign-extension unit (`SignExten`) between two immediate-generation requesters: the decode stage (requester 0) and the branch-target precompute unit (requester 1). It arbitrates between them and slices `instr[31:7]` into the extender. It registers the 32-bit result with the requester ID and tag, and delivers it on a valid/ready response channel. One result per cycle is sustained when the consumer is always ready.

## Interface
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations after which requester 1 is force-granted. Used only when `IMM_ARB_PRIO_EN` is defined. Legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_ready`  out  1  requester 0 request accepted this cycle.
- `req0_instr`  in  32  raw instruction word.
- `req0_type`  in  3  extension select: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 illegal.
- `req0_tag`  in  4  opaque tag, returned unchanged.
- `req1_valid`, `req1_ready`, `req1_instr`, `req1_type`, `req1_tag`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_imm`  out  32  sign-extended immediate.
- `rsp_id`  out  1  winning requester: 0 or 1.
- `rsp_tag`  out  4  tag of the winning request.
- `rsp_err`  out  1  type field was illegal; `rsp_imm` = 0.

## Operation
- The state machine has two states, tracked by `rsp_valid`.
  - **EMPTY**: any granted request is captured; the state moves to FULL.
  - **FULL + `rsp_ready`**: the result drains; a granted request is captured in the same cycle and the state stays FULL. With no granted request, the state moves to EMPTY.
  - **FULL + !`rsp_ready`**: everything holds; no request is accepted.
- Slot free: `slot_free` = !`rsp_valid` || `rsp_ready`.
- Ready: `reqN_ready` = `grantN` && `slot_free`. Ready depends combinationally on the valids; requesters must not make valid depend on ready.
- Requester hold rule: a requester holds valid, instr, type and tag stable until ready is seen. Dropping valid early is a protocol violation, and behaviour is undefined.
- Round-robin arbitration (default):
  - The 1-bit pointer `last` holds the most recently accepted ID.
  - With a single valid, that requester is granted.
  - With both valid, the requester ≠ `last` is granted.
  - `last` updates only on an accepted handshake, never on grant alone.
- Capture on acceptance:
  - `rsp_imm` ← SignExten(type, instr[31:7]).
  - `rsp_id`, `rsp_tag` ← the winning requester's values.
  - `rsp_err` ← (type > 3'b100).
- Illegal type: the result is accepted and returned with `rsp_imm` = 0 and `rsp_err` = 1. It is never dropped.
- Output stability: all `rsp_*` outputs are stable while `rsp_valid` && !`rsp_ready`.

## Timing
- Reset values: `rsp_valid` = 0, `rsp_imm` = 0, `rsp_id` = 0, `rsp_tag` = 0, `rsp_err` = 0. `last` = 1, so requester 0 wins the first contention. The starvation counter = 0.
- Reset mid-operation: a pending response is discarded. The `req*_ready` outputs are 0 during any cycle with `rst` high.
- Latency: a request accepted at edge N shows `rsp_valid` = 1 with its result after edge N, i.e. one cycle.
- Throughput: with `rsp_ready` held high, one result per cycle. With both requesters valid continuously, grants alternate 0,1,0,1.
- Back-pressure: with `rsp_ready` = 0 and FULL, both readies are 0 and `last` is unchanged.

## Configuration
- `IMM_ARB_PRIO_EN` not defined: round-robin arbitration as above; `STARVE_LIMIT` is unused.
- `IMM_ARB_PRIO_EN` defined: fixed priority to requester 0, with a 4-bit saturating starvation counter.
  - The counter increments on each cycle in which `req1_valid` && `slot_free` and requester 0 is accepted.
  - When the counter = `STARVE_LIMIT` and `req1_valid`, requester 1 is granted even if requester 0 is valid.
  - The counter clears on any requester-1 acceptance and on reset.

## Test plan
- I-type: req0 `instr` 0xFFF00093, `type` 000, `tag` 0x3; `rsp_ready` = 1 → one cycle later `rsp_valid` = 1, `rsp_imm` 0xFFFFFFFF, `rsp_id` 0, `rsp_tag` 0x3, `rsp_err` 0.
- B and U types: req1 `instr` 0xFE000EE3, `type` 010 → `rsp_imm` 0xFFFFFFFC. Then `instr` 0x123450B7, `type` 011 → `rsp_imm` 0x12345000; two results on consecutive cycles.
- Contention: both valid for 6 cycles with `rsp_ready` = 1 → `rsp_id` sequence 0,1,0,1,0,1. With `IMM_ARB_PRIO_EN` and `STARVE_LIMIT` = 4 → 0,0,0,0,1,0.
- Back-pressure: hold `rsp_ready` = 0 for 3 cycles while FULL with both requesters valid → both readies 0 and all `rsp_*` outputs unchanged. The first accepted grant after release goes to the requester ≠ `last`.
- Illegal type: `type` 110, `instr` 0xFFFFFFFF → `rsp_err` 1, `rsp_imm` 0x00000000, response still delivered.
- Reset mid-stream: assert `rst` while `rsp_valid` = 1 → next cycle all outputs 0. Next contention is won by requester 0.

Source files
------------

// File: rtl/imm_arbiter.sv
// Shares one immediate sign-extender between decode (id 0) and branch precompute (id 1); IMM_ARB_PRIO_EN selects fixed priority with starvation guard.
// Latency: one cycle from request acceptance to rsp_valid, sustaining one result per cycle.
// Backpressure: when the response register is full and rsp_ready is low, both req*_ready are 0 and the response and arbitration state hold.
module imm_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_instr,
    input  logic [2:0]  req0_type,
    input  logic [3:0]  req0_tag,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_instr,
    input  logic [2:0]  req1_type,
    input  logic [3:0]  req1_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_imm,
    output logic        rsp_id,
    output logic [3:0]  rsp_tag,
    output logic        rsp_err
);

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [31:0] imm;
        logic        id;
        logic [3:0]  tag;
        logic        err;
    } rsp_t;

    state_t      state_q, state_d;
    rsp_t        rsp_q, rsp_d;
    logic        last_q;
    logic        grant0, grant1, slot_free, accept;
    logic [31:0] sel_instr;
    logic [2:0]  sel_type;
    logic [3:0]  sel_tag;

    // f holds instr[31:7], so instr bit k sits at f[k-7].
    function automatic logic [31:0] sign_exten(input logic [2:0] t, input logic [24:0] f);
        logic [31:0] imm;
        case (t)
            3'b000:  imm = {{20{f[24]}}, f[24:13]};
            3'b001:  imm = {{20{f[24]}}, f[24:18], f[4:0]};
            3'b010:  imm = {{19{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
            3'b011:  imm = {f[24:5], 12'b0};
            3'b100:  imm = {{11{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

`ifdef IMM_ARB_PRIO_EN
    localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);
    logic [3:0] starve_q;
    logic       unused_instr;
    assign unused_instr = ^{req0_instr[6:0], req1_instr[6:0]};
`else
    logic       unused_instr;
    assign unused_instr = ^{req0_instr[6:0], req1_instr[6:0], 4'(STARVE_LIMIT)};
`endif

    assign rsp_valid = (state_q == FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef IMM_ARB_PRIO_EN
        grant1 = req1_valid && (!req0_valid || starve_q == LIMIT4);
        grant0 = req0_valid && !grant1;
`else
        if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
`endif
    end

    // Readies are forced low in reset so nothing is lost across it.
    assign req0_ready = grant0 && slot_free && !rst;
    assign req1_ready = grant1 && slot_free && !rst;
    assign accept     = (grant0 || grant1) && slot_free;

    always_comb begin
        sel_instr = grant1 ? req1_instr : req0_instr;
        sel_type  = grant1 ? req1_type  : req0_type;
        sel_tag   = grant1 ? req1_tag   : req0_tag;
        rsp_d.imm = sign_exten(sel_type, sel_instr[31:7]);
        rsp_d.id  = grant1;
        rsp_d.tag = sel_tag;
        rsp_d.err = (sel_type > 3'b100);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready) state_d = accept ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rsp_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_q  <= rsp_d;
                last_q <= grant1;
            end
        end
    end

`ifdef IMM_ARB_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else if (accept && grant1) begin
            starve_q <= 4'd0;
        end else if (accept && grant0 && req1_valid && starve_q != 4'hF) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`endif

    assign rsp_imm = rsp_q.imm;
    assign rsp_id  = rsp_q.id;
    assign rsp_tag = rsp_q.tag;
    assign rsp_err = rsp_q.err;

endmodule

// File: tb/tb_imm_arbiter.sv
// Directed bench for imm_arbiter: immediates, arbitration order, back-pressure, illegal type, reset.
// Expected values are hand-computed; IMM_ARB_PRIO_EN switches the arbitration expectations.
module tb_imm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_instr;
    logic [2:0]  req0_type;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_instr;
    logic [2:0]  req1_type;
    logic [3:0]  req1_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_imm;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    imm_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
        .req0_type(req0_type), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
        .req1_type(req1_type), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_imm(rsp_imm),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

`ifdef IMM_ARB_PRIO_EN
    localparam logic [5:0] CONT_IDS = 6'b010000; // bit i = id of i-th result
    localparam logic       HELD_ID  = 1'b0;
    localparam logic [3:0] HELD_TAG = 4'hA;
    localparam logic [31:0] HELD_IMM = 32'h0000_0005;
    localparam logic       REL_ID   = 1'b0;
`else
    localparam logic [5:0] CONT_IDS = 6'b101010;
    localparam logic       HELD_ID  = 1'b1;
    localparam logic [3:0] HELD_TAG = 4'hB;
    localparam logic [31:0] HELD_IMM = 32'h8000_0000;
    localparam logic       REL_ID   = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic [31:0] imm,
                           input logic id, input logic [3:0] tag, input logic err);
        chk({name, ".valid"}, {31'b0, rsp_valid}, {31'b0, v});
        chk({name, ".imm"},   rsp_imm, imm);
        chk({name, ".id"},    {31'b0, rsp_id}, {31'b0, id});
        chk({name, ".tag"},   {28'b0, rsp_tag}, {28'b0, tag});
        chk({name, ".err"},   {31'b0, rsp_err}, {31'b0, err});
    endtask

    initial begin
        logic [5:0] cont_ids;
        cont_ids = CONT_IDS;
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_instr = '0; req0_type = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_instr = '0; req1_type = '0; req1_tag = '0;
        step();
        step();
        chk_rsp("reset", 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // I-type from requester 0
        rst = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_instr = 32'hFFF0_0093; req0_type = 3'b000; req0_tag = 4'h3;
        #1;
        chk("i_ready0", {31'b0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk_rsp("itype", 1'b1, 32'hFFFF_FFFF, 1'b0, 4'h3, 1'b0);

        // B then U from requester 1 on consecutive cycles
        req1_valid = 1'b1; req1_instr = 32'hFE00_0EE3; req1_type = 3'b010; req1_tag = 4'h5;
        step();
        chk_rsp("btype", 1'b1, 32'hFFFF_FFFC, 1'b1, 4'h5, 1'b0);
        req1_instr = 32'h1234_50B7; req1_type = 3'b011; req1_tag = 4'h6;
        step();
        chk_rsp("utype", 1'b1, 32'h1234_5000, 1'b1, 4'h6, 1'b0);
        req1_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, rsp_valid}, 32'd0);

        // Contention: both valid for six cycles
        req0_valid = 1'b1; req0_instr = 32'h0050_0093; req0_type = 3'b000; req0_tag = 4'hA;
        req1_valid = 1'b1; req1_instr = 32'h8000_0037; req1_type = 3'b011; req1_tag = 4'hB;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("cont_id%0d", i), {31'b0, rsp_id}, {31'b0, cont_ids[i]});
            chk($sformatf("cont_imm%0d", i), rsp_imm,
                cont_ids[i] ? 32'h8000_0000 : 32'h0000_0005);
        end

        // Back-pressure for three cycles
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready0_%0d", i), {31'b0, req0_ready}, 32'd0);
            chk($sformatf("bp_ready1_%0d", i), {31'b0, req1_ready}, 32'd0);
            step();
            chk_rsp($sformatf("bp_hold%0d", i), 1'b1, HELD_IMM, HELD_ID, HELD_TAG, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("rel_ready0", {31'b0, req0_ready}, {31'b0, ~REL_ID});
        chk("rel_ready1", {31'b0, req1_ready}, {31'b0, REL_ID});
        step();
        chk_rsp("release", 1'b1, 32'h0000_0005, REL_ID, 4'hA, 1'b0);

        // Illegal type is delivered with zero immediate and err set
        req1_valid = 1'b0;
        req0_instr = 32'hFFFF_FFFF; req0_type = 3'b110; req0_tag = 4'h7;
        #1;
        chk("ill_ready0", {31'b0, req0_ready}, 32'd1);
        step();
        chk_rsp("illegal", 1'b1, 32'h0, 1'b0, 4'h7, 1'b1);

        // Reset while a response is pending
        req0_valid = 1'b0; rsp_ready = 1'b0;
        step();
        chk("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_type = 3'b000; req0_tag = 4'h1; req1_tag = 4'h2;
        #1;
        chk("mid_rst_ready0", {31'b0, req0_ready}, 32'd0);
        chk("mid_rst_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        chk_rsp("mid_rst", 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready0", {31'b0, req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        chk("post_rst_id", {31'b0, rsp_id}, 32'd0);
        chk("post_rst_tag", {28'b0, rsp_tag}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
